vga_sync_gen: RTL



---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_axis_counter.sv | 38 +++
 rtl/vga_sync_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants and shared types for the VGA sync generator
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;
  localparam int RGB_W   = 12;

  typedef logic [RGB_W-1:0] rgb444_t;
endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with active and sync window decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             active_o,
  output logic             sync_o
);
  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Window compares are done in int so a window ending exactly at 1024 cannot overflow.
  assign cnt_o    = r_cnt;
  assign wrap_o   = (r_cnt == LAST);
  assign active_o = (int'(r_cnt) < ACTIVE);
  assign sync_o   = (int'(r_cnt) >= SYNC_START) && (int'(r_cnt) < SYNC_END);
endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator: pixel counters plus one registered output stage
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_ce_i,
  input  rgb444_t          rgb_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             video_on_o,
  output rgb444_t          rgb_o,
  output logic             frame_start_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_timing
    $error("vga_sync_gen: total line or frame count exceeds counter range");
  end

  logic             w_h_wrap, w_h_active, w_h_sync;
  logic             w_v_wrap_unused, w_v_active, w_v_sync;
  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_video_on;

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (pix_ce_i),
    .cnt_o    (w_h_cnt),
    .wrap_o   (w_h_wrap),
    .active_o (w_h_active),
    .sync_o   (w_h_sync)
  );

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (pix_ce_i && w_h_wrap),
    .cnt_o    (w_v_cnt),
    .wrap_o   (w_v_wrap_unused),
    .active_o (w_v_active),
    .sync_o   (w_v_sync)
  );

  assign x_o        = w_h_cnt;
  assign y_o        = w_v_cnt;
  assign w_video_on = w_h_active && w_v_active;

  logic    r_hsync, r_vsync, r_video_on, r_frame_start;
  rgb444_t r_rgb;

  // Output stage samples the pre-increment counters, so everything here lags x_o/y_o by one pixel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= pix_ce_i && (w_h_cnt == '0) && (w_v_cnt == '0);
      if (pix_ce_i) begin
        r_hsync    <= w_h_sync ? SYNC_POL : ~SYNC_POL;
        r_vsync    <= w_v_sync ? SYNC_POL : ~SYNC_POL;
        r_video_on <= w_video_on;
        r_rgb      <= w_video_on ? rgb_i : '0;
      end
    end
  end

  assign hsync_o       = r_hsync;
  assign vsync_o       = r_vsync;
  assign video_on_o    = r_video_on;
  assign rgb_o         = r_rgb;
  assign frame_start_o = r_frame_start;
endmodule
